core_imem_responder: RTL and testbench

Memory-side responder for the core instruction-fetch bus (`imem_*`): accepts fetch requests, grants them after a configurable number of wait states, and returns one aligned 64-bit doubleword the cycle after the grant. Out-of-range addresses return an error instead of data. It sits between the fetch stage (the initiator) and a synchronous single-port instruction SRAM, and serves both as the simulation/FPGA instruction memory front-end and as a wait-state model for fetch-stage verification.

---
 rtl/core_imem_responder_pkg.sv | 24 ++
 rtl/core_imem_responder_lfsr.sv | 25 ++
 rtl/core_imem_responder.sv | 102 ++++++++++
 tb/tb_core_imem_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_imem_responder_pkg.sv
// Shared types and constants for the instruction-fetch memory responder.
// The optional jitter feature (CORE_IMEM_RESPONDER_JITTER_EN) uses LFSR_SEED.
package core_imem_responder_pkg;

  localparam int MEM_ADDR_R = 64;
  localparam int MEM_DATA_R = 64;
  // Wide enough for WAIT_CYCLES (max 15) plus up to 3 jitter wait states.
  localparam int CNT_W = 5;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic addr_in_range(input logic [MEM_ADDR_R-1:0] addr,
                                         input logic [MEM_ADDR_R-1:0] base,
                                         input logic [MEM_ADDR_R-1:0] size);
    logic [MEM_ADDR_R-1:0] off;
    off = addr - base;
    return (addr >= base) && (off < size);
  endfunction

endpackage

// File: rtl/core_imem_responder_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying 0-3 extra wait states.
// Only instantiated when CORE_IMEM_RESPONDER_JITTER_EN is defined.
module core_imem_responder_lfsr
  import core_imem_responder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [1:0] extra_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign extra_o = lfsr_q[1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/core_imem_responder.sv
// Instruction-fetch bus responder: grants after W wait states, returns one aligned
// doubleword the cycle after grant. CORE_IMEM_RESPONDER_JITTER_EN adds 0-3 random waits.
module core_imem_responder
  import core_imem_responder_pkg::*;
#(
  parameter logic [MEM_ADDR_R-1:0] MEM_BASE    = 64'h8000_0000,
  parameter int unsigned           MEM_SIZE    = 65536,
  parameter int unsigned           WAIT_CYCLES = 0,
  parameter int unsigned           RAM_AW      = $clog2(MEM_SIZE / 8)
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  imem_req,
  input  logic [MEM_ADDR_R-1:0] imem_addr,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_R-1:0] imem_rdata,
  output logic                  ram_cen,
  output logic [RAM_AW-1:0]     ram_addr,
  input  logic [MEM_DATA_R-1:0] ram_rdata
);

  logic [1:0] extra;

`ifdef CORE_IMEM_RESPONDER_JITTER_EN
  core_imem_responder_lfsr u_lfsr (
    .clk_i  (g_clk),
    .rst_i  (g_reset),
    .extra_o(extra)
  );
`else
  assign extra = 2'd0;
`endif

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  resp_vld_q;
  logic                  resp_err_q;
  logic [CNT_W-1:0]      wait_total;
  logic [MEM_ADDR_R-1:0] offset;
  logic                  in_range;
  logic                  fire;

  assign wait_total = CNT_W'(WAIT_CYCLES) + CNT_W'(extra);
  assign offset     = imem_addr - MEM_BASE;
  assign in_range   = addr_in_range(imem_addr, MEM_BASE, MEM_ADDR_R'(MEM_SIZE));

  // Grant depends only on request and FSM state, never on the address.
  always_comb begin
    imem_gnt = 1'b0;
    if (imem_req) begin
      case (state_q)
        ST_IDLE: imem_gnt = (wait_total == '0);
        ST_WAIT: imem_gnt = (cnt_q == '0);
        default: imem_gnt = 1'b0;
      endcase
    end
  end

  assign fire     = imem_req && imem_gnt;
  assign ram_cen  = fire && in_range;
  assign ram_addr = ram_cen ? offset[RAM_AW+2:3] : '0;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      resp_vld_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      resp_vld_q <= fire;
      resp_err_q <= fire && !in_range;
      case (state_q)
        ST_IDLE: begin
          if (imem_req && (wait_total != '0)) begin
            cnt_q   <= wait_total - CNT_W'(1);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Dropping the request abandons it; nothing is remembered.
          if (!imem_req) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_err   = resp_vld_q && resp_err_q;
  assign imem_rdata = (resp_vld_q && !resp_err_q) ? ram_rdata : '0;

  logic unused_offset;
  assign unused_offset = ^{offset[MEM_ADDR_R-1:RAM_AW+3], offset[2:0]};

endmodule

// File: tb/tb_core_imem_responder.sv
// Bench for core_imem_responder: three instances (0, 2, 3 wait states) against an SRAM
// model and a cycle-level reference built from the bus rules.
module tb_core_imem_responder;

  localparam logic [63:0] BASE   = 64'h8000_0000;
  localparam int unsigned SIZE   = 65536;
  localparam int          AW     = 13;
  localparam int          NWORDS = SIZE / 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          req;
  logic [2:0][63:0]    addr;
  logic [2:0]          gnt;
  logic [2:0]          err;
  logic [2:0]          ram_cen;
  logic [2:0][63:0]    rdata;
  logic [2:0][63:0]    ram_rdata;
  logic [2:0][AW-1:0]  ram_addr;
  logic [63:0]         mem [NWORDS];

  int n_checks = 0;
  int n_errs   = 0;
  int cur      = 0;
  int run      = 0;
  logic [64:0] exp_q[$];

  logic          exp_gnt;
  logic          exp_cen;
  logic          exp_err;
  logic [AW-1:0] exp_raddr;
  logic [63:0]   exp_rdata;

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int unsigned WC = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    core_imem_responder #(
      .MEM_BASE   (BASE),
      .MEM_SIZE   (SIZE),
      .WAIT_CYCLES(WC)
    ) u_dut (
      .g_clk     (clk),
      .g_reset   (rst),
      .imem_req  (req[g]),
      .imem_addr (addr[g]),
      .imem_gnt  (gnt[g]),
      .imem_err  (err[g]),
      .imem_rdata(rdata[g]),
      .ram_cen   (ram_cen[g]),
      .ram_addr  (ram_addr[g]),
      .ram_rdata (ram_rdata[g])
    );
  end

  // Synchronous SRAM: data appears the cycle after the enable.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ram_cen[g]) ram_rdata[g] <= mem[ram_addr[g]];
    end
  end

  // ---------------- reference model ----------------
  function automatic int wait_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 2 : 3;
  endfunction

  function automatic logic in_mem(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(SIZE));
  endfunction

  // Expectations for the current cycle; call at the sampling point.
  task automatic eval();
    logic [64:0] r;
    exp_gnt   = req[cur] && (run == wait_of(cur));
    exp_cen   = exp_gnt && in_mem(addr[cur]);
    exp_raddr = AW'((addr[cur] - BASE) / 8);
    r         = (exp_q.size() > 0) ? exp_q.pop_front() : 65'd0;
    exp_err   = r[64];
    exp_rdata = r[63:0];
  endtask

  // Commit this cycle into the model and move to just after the next edge.
  task automatic advance();
    if (exp_gnt) exp_q.push_back(in_mem(addr[cur]) ? {1'b0, mem[exp_raddr]} : {1'b1, 64'd0});
    run = (req[cur] && !exp_gnt) ? run + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    run = 0;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++; if (gnt[g] !== 1'b0)     begin n_errs++; $display("FAIL reset_gnt inst=%0d got=%b exp=0", g, gnt[g]); end
      n_checks++; if (err[g] !== 1'b0)     begin n_errs++; $display("FAIL reset_err inst=%0d got=%b exp=0", g, err[g]); end
      n_checks++; if (rdata[g] !== 64'd0)  begin n_errs++; $display("FAIL reset_rdata inst=%0d got=%h exp=0", g, rdata[g]); end
      n_checks++; if (ram_cen[g] !== 1'b0) begin n_errs++; $display("FAIL reset_cen inst=%0d got=%b exp=0", g, ram_cen[g]); end
      n_checks++; if (ram_addr[g] !== '0)  begin n_errs++; $display("FAIL reset_raddr inst=%0d got=%h exp=0", g, ram_addr[g]); end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++; if ({gnt[g], err[g], ram_cen[g]} !== 3'b000 || rdata[g] !== 64'd0) begin
        n_errs++; $display("FAIL post_reset_idle inst=%0d gnt=%b err=%b cen=%b rdata=%h exp all 0", g, gnt[g], err[g], ram_cen[g], rdata[g]);
      end
    end
    model_reset();
  endtask

  task automatic test_full_throughput();
    cur = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      req[cur]  = (i < 4);
      addr[cur] = BASE + 64'(8 * i);
      @(negedge clk); eval();
      n_checks++; if (gnt[cur] !== exp_gnt)     begin n_errs++; $display("FAIL tput_gnt cyc=%0d got=%b exp=%b", i, gnt[cur], exp_gnt); end
      n_checks++; if (ram_cen[cur] !== exp_cen) begin n_errs++; $display("FAIL tput_cen cyc=%0d got=%b exp=%b", i, ram_cen[cur], exp_cen); end
      if (exp_cen) begin n_checks++; if (ram_addr[cur] !== exp_raddr) begin n_errs++; $display("FAIL tput_raddr cyc=%0d got=%h exp=%h", i, ram_addr[cur], exp_raddr); end end
      n_checks++; if (rdata[cur] !== exp_rdata) begin n_errs++; $display("FAIL tput_rdata cyc=%0d got=%h exp=%h", i, rdata[cur], exp_rdata); end
      n_checks++; if (err[cur] !== exp_err)     begin n_errs++; $display("FAIL tput_err cyc=%0d got=%b exp=%b", i, err[cur], exp_err); end
      advance();
    end
  endtask

  task automatic test_wait_states();
    cur = 1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      req[cur]  = (i <= 2);
      addr[cur] = BASE + 64'h10;
      @(negedge clk); eval();
      n_checks++; if (gnt[cur] !== exp_gnt)     begin n_errs++; $display("FAIL wait2_gnt cyc=%0d got=%b exp=%b", i, gnt[cur], exp_gnt); end
      n_checks++; if (ram_cen[cur] !== exp_cen) begin n_errs++; $display("FAIL wait2_cen cyc=%0d got=%b exp=%b", i, ram_cen[cur], exp_cen); end
      if (exp_cen) begin n_checks++; if (ram_addr[cur] !== exp_raddr) begin n_errs++; $display("FAIL wait2_raddr cyc=%0d got=%h exp=%h", i, ram_addr[cur], exp_raddr); end end
      n_checks++; if (rdata[cur] !== exp_rdata) begin n_errs++; $display("FAIL wait2_rdata cyc=%0d got=%h exp=%h", i, rdata[cur], exp_rdata); end
      n_checks++; if (err[cur] !== exp_err)     begin n_errs++; $display("FAIL wait2_err cyc=%0d got=%b exp=%b", i, err[cur], exp_err); end
      advance();
    end
  endtask

  task automatic test_abandon();
    logic [7:0] pat;
    pat = 8'b0111_1011;
    cur = 2;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      req[cur]  = pat[i];
      addr[cur] = BASE + 64'(8 * $urandom_range(0, NWORDS - 1));
      @(negedge clk); eval();
      n_checks++; if (gnt[cur] !== exp_gnt)     begin n_errs++; $display("FAIL abandon_gnt cyc=%0d got=%b exp=%b", i, gnt[cur], exp_gnt); end
      n_checks++; if (ram_cen[cur] !== exp_cen) begin n_errs++; $display("FAIL abandon_cen cyc=%0d got=%b exp=%b", i, ram_cen[cur], exp_cen); end
      if (exp_cen) begin n_checks++; if (ram_addr[cur] !== exp_raddr) begin n_errs++; $display("FAIL abandon_raddr cyc=%0d got=%h exp=%h", i, ram_addr[cur], exp_raddr); end end
      n_checks++; if (rdata[cur] !== exp_rdata) begin n_errs++; $display("FAIL abandon_rdata cyc=%0d got=%h exp=%h", i, rdata[cur], exp_rdata); end
      n_checks++; if (err[cur] !== exp_err)     begin n_errs++; $display("FAIL abandon_err cyc=%0d got=%b exp=%b", i, err[cur], exp_err); end
      advance();
    end
  endtask

  task automatic test_boundaries();
    logic [63:0] tbl [6];
    tbl = '{64'h8000_FFF8, 64'h8001_0000, 64'h7FFF_FFF8, 64'h8000_0006,
            64'hFFFF_FFFF_FFFF_FFF8, 64'h0};
    cur = 0;
    model_reset();
    for (int i = 0; i < 7; i++) begin
      req[cur]  = (i < 6);
      addr[cur] = (i < 6) ? tbl[i] : 64'h0;
      @(negedge clk); eval();
      n_checks++; if (gnt[cur] !== exp_gnt)     begin n_errs++; $display("FAIL bound_gnt cyc=%0d got=%b exp=%b", i, gnt[cur], exp_gnt); end
      n_checks++; if (ram_cen[cur] !== exp_cen) begin n_errs++; $display("FAIL bound_cen cyc=%0d got=%b exp=%b", i, ram_cen[cur], exp_cen); end
      if (exp_cen) begin n_checks++; if (ram_addr[cur] !== exp_raddr) begin n_errs++; $display("FAIL bound_raddr cyc=%0d got=%h exp=%h", i, ram_addr[cur], exp_raddr); end end
      n_checks++; if (rdata[cur] !== exp_rdata) begin n_errs++; $display("FAIL bound_rdata cyc=%0d got=%h exp=%h", i, rdata[cur], exp_rdata); end
      n_checks++; if (err[cur] !== exp_err)     begin n_errs++; $display("FAIL bound_err cyc=%0d got=%b exp=%b", i, err[cur], exp_err); end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    cur = 1;
    model_reset();
    // Reset in the response cycle discards the response.
    for (int i = 0; i < 3; i++) begin
      req[cur]  = 1'b1;
      addr[cur] = BASE + 64'(8 * $urandom_range(0, NWORDS - 1));
      @(negedge clk); eval();
      n_checks++; if (gnt[cur] !== exp_gnt) begin n_errs++; $display("FAIL rstresp_gnt cyc=%0d got=%b exp=%b", i, gnt[cur], exp_gnt); end
      advance();
    end
    req[cur] = 1'b0;
    rst      = 1'b1;
    #1;
    n_checks++; if (rdata[cur] !== 64'd0) begin n_errs++; $display("FAIL rstresp_rdata got=%h exp=0", rdata[cur]); end
    n_checks++; if (err[cur] !== 1'b0)    begin n_errs++; $display("FAIL rstresp_err got=%b exp=0", err[cur]); end
    n_checks++; if (gnt[cur] !== 1'b0)    begin n_errs++; $display("FAIL rstresp_gnt got=%b exp=0", gnt[cur]); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    // Reset while waiting: the wait count restarts from scratch.
    req[cur]  = 1'b1;
    addr[cur] = BASE + 64'h40;
    @(negedge clk); eval();
    n_checks++; if (gnt[cur] !== exp_gnt) begin n_errs++; $display("FAIL rstwait_first_gnt got=%b exp=%b", gnt[cur], exp_gnt); end
    advance();
    rst = 1'b1;
    #1;
    n_checks++; if (gnt[cur] !== 1'b0) begin n_errs++; $display("FAIL rstwait_gnt_in_reset got=%b exp=0", gnt[cur]); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      req[cur] = (i < 3);
      @(negedge clk); eval();
      n_checks++; if (gnt[cur] !== exp_gnt)     begin n_errs++; $display("FAIL rstwait_gnt cyc=%0d got=%b exp=%b", i, gnt[cur], exp_gnt); end
      n_checks++; if (ram_cen[cur] !== exp_cen) begin n_errs++; $display("FAIL rstwait_cen cyc=%0d got=%b exp=%b", i, ram_cen[cur], exp_cen); end
      n_checks++; if (rdata[cur] !== exp_rdata) begin n_errs++; $display("FAIL rstwait_rdata cyc=%0d got=%h exp=%h", i, rdata[cur], exp_rdata); end
      n_checks++; if (err[cur] !== exp_err)     begin n_errs++; $display("FAIL rstwait_err cyc=%0d got=%b exp=%b", i, err[cur], exp_err); end
      advance();
    end
  endtask

  task automatic test_random();
    for (int g = 0; g < 3; g++) begin
      cur = g;
      model_reset();
      for (int i = 0; i < 41; i++) begin
        req[cur] = (i < 40) && ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 3) != 0) addr[cur] = BASE + 64'($urandom_range(0, SIZE - 1));
        else addr[cur] = {$urandom(), $urandom()};
        @(negedge clk); eval();
        n_checks++; if (gnt[cur] !== exp_gnt)     begin n_errs++; $display("FAIL rand_gnt inst=%0d cyc=%0d got=%b exp=%b", g, i, gnt[cur], exp_gnt); end
        n_checks++; if (ram_cen[cur] !== exp_cen) begin n_errs++; $display("FAIL rand_cen inst=%0d cyc=%0d got=%b exp=%b", g, i, ram_cen[cur], exp_cen); end
        if (exp_cen) begin n_checks++; if (ram_addr[cur] !== exp_raddr) begin n_errs++; $display("FAIL rand_raddr inst=%0d cyc=%0d got=%h exp=%h", g, i, ram_addr[cur], exp_raddr); end end
        n_checks++; if (rdata[cur] !== exp_rdata) begin n_errs++; $display("FAIL rand_rdata inst=%0d cyc=%0d got=%h exp=%h", g, i, rdata[cur], exp_rdata); end
        n_checks++; if (err[cur] !== exp_err)     begin n_errs++; $display("FAIL rand_err inst=%0d cyc=%0d got=%b exp=%b", g, i, err[cur], exp_err); end
        advance();
      end
      req[cur] = 1'b0;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < NWORDS; i++) mem[i] = {$urandom(), $urandom()};
    test_reset();
    test_full_throughput();
    test_wait_states();
    test_abandon();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
